// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: sequences received bytes (A, B, opcode) into an ALU and transmits the result
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_tick                    baud tick that drives the inter-byte timeout
//   i_rx_data, i_rx_valid     received byte and its 1-cycle strobe
//   i_alu_result              combinational ALU result of o_alu_a/o_alu_b/o_alu_op
//   i_tx_done                 transmitter finished the byte
//   o_alu_a, o_alu_b, o_alu_op  registered frame driving the ALU
//   o_tx_data, o_tx_start     result byte and its 1-cycle start pulse
//   o_busy                    frame or transmit in progress
//   o_err                     frame dropped (timeout or illegal opcode)
//   o_overrun                 byte dropped while executing/transmitting
module uart_alu_ctrl #(
    parameter int NB_DATA       = 8,
    parameter int NB_OP         = 6,
    parameter int TIMEOUT_TICKS = 2048
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_err,
    output logic               o_overrun
);
    localparam int NB_CNT = $clog2(TIMEOUT_TICKS);
    localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(TIMEOUT_TICKS - 1);

    typedef enum logic [2:0] {IDLE, GET_B, GET_OP, EXEC, WAIT_TX} state_t;

    state_t             state, state_n;
    logic [NB_CNT-1:0]  cnt, cnt_n;
    logic [NB_DATA-1:0] a_n, b_n, tx_data_n;
    logic [NB_OP-1:0]   op_n, opcode;
    logic               start_n, err_n, overrun_n, legal, expire;

    assign opcode = i_rx_data[NB_OP-1:0];
    assign legal  = opcode inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
    // a received byte takes priority over a tick expiring in the same cycle
    assign expire = i_tick && cnt == CNT_MAX;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            cnt        <= '0;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_err      <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            o_alu_a    <= a_n;
            o_alu_b    <= b_n;
            o_alu_op   <= op_n;
            o_tx_data  <= tx_data_n;
            o_tx_start <= start_n;
            o_busy     <= state_n != IDLE;
            o_err      <= err_n;
            o_overrun  <= overrun_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        a_n       = o_alu_a;
        b_n       = o_alu_b;
        op_n      = o_alu_op;
        tx_data_n = o_tx_data;
        start_n   = 1'b0;
        err_n     = 1'b0;
        overrun_n = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (i_rx_valid) begin
                    a_n     = i_rx_data;
                    state_n = GET_B;
                end
            end
            GET_B, GET_OP: begin
                if (i_rx_valid) begin
                    cnt_n = '0;
                    if (state == GET_B) begin
                        b_n     = i_rx_data;
                        state_n = GET_OP;
                    end else if (legal) begin
                        op_n    = opcode;
                        state_n = EXEC;
                    end else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end else if (expire) begin
                    cnt_n   = '0;
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (i_tick) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            EXEC: begin
                tx_data_n = i_alu_result;
                start_n   = 1'b1;
                overrun_n = i_rx_valid;
                state_n   = WAIT_TX;
            end
            WAIT_TX: begin
                overrun_n = i_rx_valid;
                state_n   = i_tx_done ? IDLE : WAIT_TX;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
